// File: rtl/display_sequencer.sv
// display_sequencer: game-level controller for the seven-segment/LED display.
// Steps the game through IDLE, PLAY, OVER and QUIT using event pulses from the
// tile-matching logic. It tracks the score and the remaining lives, and drives
// the display holder nibbles, the mode flags and the LEDR pattern.
// Optional feature: define HIGH_SCORE_EN to keep a best-score register. IDLE
// then shows that best score in place of the cleared score.
module display_sequencer #(
  parameter int BLINK_DIV   = 25000000,
  parameter int MAX_SCORE   = 32,
  parameter int START_LIVES = 9
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       userquit_in,
  input  logic       match_pulse,
  input  logic       miss_pulse,
  output logic       userquit,
  output logic       ingameOn,
  output logic       gameOver,
  output logic [3:0] hex0hldr,
  output logic [3:0] hex4hldr,
  output logic [3:0] hex5hldr,
  output logic [9:0] ledrhldr
);

  localparam int         CW         = $clog2(BLINK_DIV);
  localparam logic [5:0] MAX_S      = 6'(MAX_SCORE);
  localparam logic [3:0] START_L    = 4'(START_LIVES);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_OVER, ST_QUIT} state_t;

  state_t        state_reg;
  logic [5:0]    score_reg;
  logic [3:0]    lives_reg;
  logic [CW-1:0] blink_cnt_reg;
  logic          phase_reg;
  logic [5:0]    score_next;
  logic [3:0]    lives_next;
  logic          play_end;
  logic [5:0]    idle_disp;

`ifdef HIGH_SCORE_EN
  logic [5:0]    best_reg;
`endif

  // Saturating score/lives updates while playing; end test uses updated values
  always_comb begin
    score_next = score_reg;
    lives_next = lives_reg;
    if (match_pulse && (score_reg < MAX_S)) score_next = score_reg + 6'd1;
    if (miss_pulse && (lives_reg != 4'd0))  lives_next = lives_reg - 4'd1;
    play_end = (score_next == MAX_S) || (lives_next == 4'd0);
  end

  // Game FSM together with its score, lives and OVER blink registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      score_reg     <= 6'd0;
      lives_reg     <= 4'd0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
`ifdef HIGH_SCORE_EN
      best_reg      <= 6'd0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_PLAY;
            score_reg <= 6'd0;
            lives_reg <= START_L;
          end else if (userquit_in) begin
            state_reg <= ST_QUIT;
          end
        end
        ST_PLAY: begin
          score_reg <= score_next;
          lives_reg <= lives_next;
          if (userquit_in) begin
            state_reg <= ST_QUIT;
          end else if (play_end) begin
            state_reg     <= ST_OVER;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b1;
          end
`ifdef HIGH_SCORE_EN
          // Leaving play by either route records the final score
          if ((userquit_in || play_end) && (score_next > best_reg))
            best_reg <= score_next;
`endif
        end
        ST_OVER: begin
          if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
          end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
          end
          if (userquit_in) begin
            state_reg <= ST_QUIT;
          end else if (start) begin
            state_reg <= ST_PLAY;
            score_reg <= 6'd0;
            lives_reg <= START_L;
          end
        end
        default: begin
          if (start) begin
            state_reg <= ST_IDLE;
            score_reg <= 6'd0;
          end
        end
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  assign idle_disp = best_reg;
`else
  assign idle_disp = score_reg;
`endif

  // Moore decode of the display holders from registered state only
  always_comb begin
    userquit = 1'b0;
    ingameOn = 1'b0;
    gameOver = 1'b0;
    hex0hldr = 4'hA;
    hex4hldr = idle_disp[3:0];
    hex5hldr = {2'b00, idle_disp[5:4]};
    ledrhldr = 10'h000;
    case (state_reg)
      ST_PLAY: begin
        ingameOn = 1'b1;
        hex0hldr = lives_reg;
        hex4hldr = score_reg[3:0];
        hex5hldr = {2'b00, score_reg[5:4]};
        ledrhldr = (10'd1 << lives_reg) - 10'd1;
      end
      ST_OVER: begin
        gameOver = 1'b1;
        hex0hldr = 4'hE;
        hex4hldr = score_reg[3:0];
        hex5hldr = {2'b00, score_reg[5:4]};
        ledrhldr = phase_reg ? 10'h3FF : 10'h000;
      end
      ST_QUIT: begin
        userquit = 1'b1;
        hex0hldr = 4'hF;
        hex4hldr = 4'hF;
        hex5hldr = 4'hF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer (BLINK_DIV=4). Expected output
// vectors are queued as stimulus is applied and compared once the DUT has
// produced the corresponding outputs.
module tb_display_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       userquit_in = 1'b0;
  logic       match_pulse = 1'b0;
  logic       miss_pulse = 1'b0;
  logic       userquit, ingameOn, gameOver;
  logic [3:0] hex0hldr, hex4hldr, hex5hldr;
  logic [9:0] ledrhldr;
  logic [24:0] obs_vec;

  int tests = 0;
  int failed = 0;
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  string       name_q[$];

`ifdef HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  display_sequencer #(.BLINK_DIV(4), .MAX_SCORE(32), .START_LIVES(9)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
    .userquit_in(userquit_in), .match_pulse(match_pulse), .miss_pulse(miss_pulse),
    .userquit(userquit), .ingameOn(ingameOn), .gameOver(gameOver),
    .hex0hldr(hex0hldr), .hex4hldr(hex4hldr), .hex5hldr(hex5hldr),
    .ledrhldr(ledrhldr)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign obs_vec = {userquit, ingameOn, gameOver, hex0hldr, hex4hldr, hex5hldr, ledrhldr};

  function automatic logic [24:0] v_idle(input logic [5:0] s);
    return {3'b000, 4'hA, s[3:0], 2'b00, s[5:4], 10'h000};
  endfunction

  function automatic logic [24:0] v_play(input logic [5:0] s, input logic [3:0] l);
    logic [9:0] t;
    t = '0;
    for (int i = 0; i < 10; i++) if (i < int'(l)) t[i] = 1'b1;
    return {3'b010, l, s[3:0], 2'b00, s[5:4], t};
  endfunction

  function automatic logic [24:0] v_over(input logic [5:0] s, input logic ph);
    return {3'b001, 4'hE, s[3:0], 2'b00, s[5:4], (ph ? 10'h3FF : 10'h000)};
  endfunction

  function automatic logic [24:0] v_quit();
    return {3'b100, 4'hF, 4'hF, 4'hF, 10'h000};
  endfunction

  // Queue one expected output vector for the next cycle
  task automatic expect_v(input string n, input logic [24:0] v);
    exp_q.push_back(v);
    name_q.push_back(n);
  endtask

  // Apply inputs across one rising edge, then record the outputs
  task automatic cycle(input logic s, input logic q, input logic ma, input logic mi);
    start = s; userquit_in = q; match_pulse = ma; miss_pulse = mi;
    @(posedge CLOCK_50);
    #1;
    obs_q.push_back(obs_vec);
    start = 1'b0; userquit_in = 1'b0; match_pulse = 1'b0; miss_pulse = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] e, o;
    string n;
    resetn = 1'b0;
    #1;
    expect_v("reset_state", v_idle(6'd0));
    obs_q.push_back(obs_vec);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    expect_v("idle_hold", v_idle(6'd0));
    cycle(0, 0, 1, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s: no output, required %h", n, e); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin failed++; $display("FAIL %s: got %h required %h", n, o, e); end end
    end
  endtask

  task automatic test_idle_priority();
    logic [24:0] e, o;
    string n;
    expect_v("idle_start_wins", v_play(6'd0, 4'd9)); cycle(1, 1, 0, 0);
    expect_v("play_quit", v_quit());                 cycle(0, 1, 0, 0);
    expect_v("quit_to_idle", v_idle(6'd0));          cycle(1, 0, 0, 0);
    expect_v("idle_quit", v_quit());                 cycle(0, 1, 0, 0);
    expect_v("quit_ignores", v_quit());              cycle(0, 1, 1, 1);
    expect_v("quit_to_idle2", v_idle(6'd0));         cycle(1, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s: no output, required %h", n, e); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin failed++; $display("FAIL %s: got %h required %h", n, o, e); end end
    end
  endtask

  task automatic test_score();
    logic [24:0] e, o;
    string n;
    expect_v("start_play", v_play(6'd0, 4'd9)); cycle(1, 0, 0, 0);
    for (int i = 1; i <= 31; i++) begin
      expect_v($sformatf("match_%0d", i), v_play(6'(i), 4'd9));
      cycle(i == 5, 0, 1, 0);
    end
    expect_v("match_32_over", v_over(6'd32, 1'b1)); cycle(0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      expect_v($sformatf("blink_%0d", k), v_over(6'd32, ((k >> 2) & 1) == 0));
      cycle(0, 0, 1, 1);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s: no output, required %h", n, e); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin failed++; $display("FAIL %s: got %h required %h", n, o, e); end end
    end
  endtask

  task automatic test_miss();
    logic [24:0] e, o;
    string n;
    expect_v("restart_play", v_play(6'd0, 4'd9)); cycle(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      expect_v($sformatf("miss_%0d", i), v_play(6'd0, 4'(9 - i)));
      cycle(0, 0, 0, 1);
    end
    expect_v("miss_9_over", v_over(6'd0, 1'b1)); cycle(0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      expect_v($sformatf("miss_blink_%0d", k), v_over(6'd0, ((k >> 2) & 1) == 0));
      cycle(0, 0, 0, 0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s: no output, required %h", n, e); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin failed++; $display("FAIL %s: got %h required %h", n, o, e); end end
    end
  endtask

  task automatic test_simultaneous();
    logic [24:0] e, o;
    string n;
    expect_v("sim_start", v_play(6'd0, 4'd9)); cycle(1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin expect_v("sim_match", v_play(6'(i), 4'd9)); cycle(0, 0, 1, 0); end
    for (int i = 1; i <= 8; i++) begin expect_v("sim_miss", v_play(6'd5, 4'(9 - i))); cycle(0, 0, 0, 1); end
    expect_v("match_miss_over", v_over(6'd6, 1'b1)); cycle(0, 0, 1, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s: no output, required %h", n, e); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin failed++; $display("FAIL %s: got %h required %h", n, o, e); end end
    end
  endtask

  task automatic test_quit();
    logic [24:0] e, o;
    string n;
    expect_v("over_quit_wins", v_quit());          cycle(1, 1, 0, 0);
    expect_v("quit_hold", v_quit());               cycle(0, 0, 1, 1);
    expect_v("quit_to_idle_best", v_idle(HS ? 6'd32 : 6'd0)); cycle(1, 0, 0, 0);
    expect_v("idle_ignores_pulses", v_idle(HS ? 6'd32 : 6'd0)); cycle(0, 0, 1, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s: no output, required %h", n, e); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin failed++; $display("FAIL %s: got %h required %h", n, o, e); end end
    end
  endtask

  task automatic test_async_reset();
    logic [24:0] e, o;
    string n;
    expect_v("ar_start", v_play(6'd0, 4'd9)); cycle(1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin expect_v("ar_match", v_play(6'(i), 4'd9)); cycle(0, 0, 1, 0); end
    #2;
    resetn = 1'b0;
    #1;
    expect_v("async_reset", v_idle(6'd0));
    obs_q.push_back(obs_vec);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    expect_v("hs_start", v_play(6'd0, 4'd9)); cycle(1, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin expect_v("hs_match", v_play(6'(i), 4'd9)); cycle(0, 0, 1, 0); end
    expect_v("hs_quit", v_quit()); cycle(0, 1, 0, 0);
    expect_v("hs_idle", v_idle(HS ? 6'd12 : 6'd0)); cycle(1, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s: no output, required %h", n, e); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin failed++; $display("FAIL %s: got %h required %h", n, o, e); end end
    end
  endtask

  initial begin
    test_reset();
    test_idle_priority();
    test_score();
    test_miss();
    test_simultaneous();
    test_quit();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
